instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the 32-bit MIPS pipeline; sits directly upstream of the instruction memory.
//  Owns the PC, drives the word address into instruction memory and captures the returned word.
//  Captured word goes into the IF/ID pipeline register for decode.
//  Handles stall, flush and branch/jump redirect from later stages.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte address of first fetch after reset
//  IMEM_DEPTH  128            instruction memory depth in words; word index >= depth is a fault
//  NOP_WORD    32'h0000_0000  word injected on flush/fault (sll $0,$0,0)
// PORTS
//  clk              in   1   rising-edge clock
//  rst_n            in   1   asynchronous, active-low reset
//  stall            in   1   hazard unit: hold PC and IF/ID
//  flush            in   1   squash IF/ID contents next edge
//  redirect_valid   in   1   taken branch/jump this cycle
//  redirect_target  in   32  byte target; bits[1:0] ignored (forced 0)
//  imem_addr        out  32  word index = pc[31:2], zero-extended; combinational from pc
//  imem_instr       in   32  word returned by instruction memory (combinational read)
//  if_id_instr      out  32  registered instruction to decode
//  if_id_pc_plus4   out  32  registered PC+4 of that instruction
//  if_id_valid      out  1   registered: IF/ID holds a real instruction
//  fetch_fault      out  1   registered: FSM in FAULT
//  pc_out           out  32  current PC (debug)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC; if_id_instr=NOP_WORD; if_id_pc_plus4=0;
//    if_id_valid=0; fetch_fault=0; state=BOOT.
//  FSM: BOOT -> RUN unconditionally on first edge after reset release.
//    BOOT: pc held at RESET_PC; IF/ID stays invalid.
//    RUN -> FAULT when unstalled fetch has imem_addr >= IMEM_DEPTH.
//    FAULT -> RUN on redirect_valid; otherwise sticky until reset.
//  RUN, per edge, priority order:
//    1) redirect_valid: pc <= {target[31:2],2'b00}. Applies even when stall=1.
//    2) else if stall: pc holds.
//    3) else: pc <= pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
//  IF/ID register, priority order:
//    1) flush: instr=NOP_WORD, valid=0. Flush beats stall.
//    2) else if stall: hold all fields.
//    3) else if in-range fetch: instr=imem_instr, pc_plus4=pc+4, valid=1.
//    4) else (out-of-range fetch): instr=NOP_WORD, valid=0.
//  redirect_valid without flush: the wrong-path word already fetched is still captured.
//    Hazard unit must assert flush together with redirect.
//  FAULT: pc holds; IF/ID loads NOP/invalid each edge; fetch_fault=1.
//  Latency: instruction at PC p appears on if_id_instr one edge after pc==p with stall=0.
//  Reset mid-operation clears everything immediately (async); no partial state survives.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_stalls[31:0].
//    perf_fetched: increments on every edge that loads a valid=1 word into IF/ID.
//    perf_stalls: increments on every RUN edge with stall=1 and flush=0.
//    Both reset to 0; both wrap at 2^32.
//  IF_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pkg: NOP_WORD, RESET_PC, IMEM_DEPTH defaults; fetch-state encoding.
//    Fetch-state encoding: BOOT=2'd0, RUN=2'd1, FAULT=2'd2.
//  One sub-module: if_id_pipe_reg (instr, pc_plus4, valid; stall/flush priority).
//  PC/next-PC mux, FSM and optional counters stay in this module.
// TESTING
//  Reset release, stall=0, imem returns IMEM[0]=0x00221820, IMEM[1]=0x01255022:
//    -> cycle 1 BOOT, valid=0; then if_id_instr=0x00221820 with pc_plus4=4,
//    -> then 0x01255022 with pc_plus4=8.
//  stall=1 for 3 cycles at pc=8 -> pc stays 8; IF/ID holds sub word; valid=1 throughout.
//  redirect_valid=1, target=0x0000_0013, flush=1 -> next pc=0x10; if_id_valid=0 one cycle.
//  stall=1 + flush=1 same edge -> IF/ID NOP/invalid; pc holds.
//  pc reaches 0x200 (word 128, IMEM_DEPTH=128) -> fetch_fault=1, valid=0, pc frozen.
//    redirect to 0 -> RUN, fault clears next edge.
//  Assert rst_n low mid-stream with stall=1 -> outputs reset values immediately, no clock.
//    With IF_PERF_CNT_EN: counters read 0 after reset; 5 fetches + 2 stalls -> 5/2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults and fetch-state encoding.
package mips_pkg;

   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int unsigned IMEM_DEPTH = 128;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush beats stall; an unloadable fetch becomes a NOP bubble.
module if_id_pipe_reg #(
   parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        stall,
   input  logic        load,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_plus4_d,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   // pc_plus4 is left alone on bubbles; it is meaningless while valid=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr    <= NOP_WORD;
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (flush) begin
         instr <= NOP_WORD;
         valid <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            instr    <= instr_d;
            pc_plus4 <= pc_plus4_d;
            valid    <= 1'b1;
         end else begin
            instr <= NOP_WORD;
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC, next-PC mux, BOOT/RUN/FAULT FSM and the IF/ID register.
// IF_PERF_CNT_EN adds perf_fetched / perf_stalls counters.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
   parameter int unsigned IMEM_DEPTH = mips_pkg::IMEM_DEPTH,
   parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        fetch_fault,
   output logic [31:0] pc_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
`endif
);

   import mips_pkg::*;

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt, pc_plus4, target;
   logic         in_range, running;

   assign imem_addr   = {2'b00, pc[31:2]};
   assign pc_plus4    = pc + 32'd4;
   assign target      = {redirect_target[31:2], 2'b00};
   assign in_range    = imem_addr < IMEM_DEPTH;
   assign running     = (state == RUN);
   assign pc_out      = pc;
   assign fetch_fault = (state == FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   // A redirect arriving with an out-of-range fetch already repairs the PC, so no fault.
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (!redirect_valid && !stall && !in_range) state_nxt = FAULT;
         FAULT:   if (redirect_valid) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      pc_nxt = pc;
      case (state)
         RUN: begin
            if (redirect_valid)        pc_nxt = target;
            else if (!stall && in_range) pc_nxt = pc_plus4;
         end
         FAULT:   if (redirect_valid) pc_nxt = target;
         default: pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_nxt;
   end

   // Outside RUN the register is forced to a bubble regardless of stall.
   if_id_pipe_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush | ~running),
      .stall      (stall),
      .load       (in_range),
      .instr_d    (imem_instr),
      .pc_plus4_d (pc_plus4),
      .instr      (if_id_instr),
      .pc_plus4   (if_id_pc_plus4),
      .valid      (if_id_valid)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (running && !flush && !stall && in_range) perf_fetched <= perf_fetched + 32'd1;
         if (running && stall && !flush)              perf_stalls  <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage; IF_PERF_CNT_EN also checks the counters.
module tb_instruction_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc_plus4, pc_out;
   logic        if_id_valid, fetch_fault;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stalls;
`endif

   logic [31:0] mem [128];
   logic [63:0] sb [$];

   // bench model of expected architectural state
   logic [31:0] m_pc, m_instr, m_fetched, m_stalls;
   logic        m_run, m_fault, m_valid, m_boot;

   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      if (imem_addr < 32'd128) imem_instr = mem[imem_addr[6:0]];
      else                     imem_instr = 32'hDEAD_BEEF;
   end

   instruction_fetch_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .if_id_instr     (if_id_instr),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .if_id_valid     (if_id_valid),
      .fetch_fault     (fetch_fault),
      .pc_out          (pc_out)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched    (perf_fetched),
      .perf_stalls     (perf_stalls)
`endif
   );

   task automatic model_reset();
      m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_boot = 1'b1; m_run = 1'b0; m_fault = 1'b0;
      m_fetched = 0; m_stalls = 0;
      sb.delete();
   endtask

   // Drive one cycle, advance the model, then consume the scoreboard on the DUT output.
   task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] tgt);
      logic        push;
      logic [63:0] e;
      stall = s; flush = f; redirect_valid = rv; redirect_target = tgt;
      push = m_run && !f && !s && (m_pc[31:2] < 30'd128);
      if (push) begin
         sb.push_back({mem[m_pc[8:2]], m_pc + 32'd4});
         m_fetched++;
      end
      if (m_run && s && !f) m_stalls++;
      if (push) m_valid = 1'b1;
      else if (!(m_run && s && !f)) begin m_valid = 1'b0; m_instr = NOP; end
      if (m_boot) begin
         m_boot = 1'b0; m_run = 1'b1;
      end else if (m_fault) begin
         if (rv) begin m_fault = 1'b0; m_run = 1'b1; m_pc = {tgt[31:2], 2'b00}; end
      end else begin
         if (rv)                                m_pc = {tgt[31:2], 2'b00};
         else if (!s && m_pc[31:2] >= 30'd128) begin m_fault = 1'b1; m_run = 1'b0; end
         else if (!s)                           m_pc = m_pc + 32'd4;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (pc_out !== m_pc || imem_addr !== {2'b00, m_pc[31:2]}) begin
         n_bad++; $display("FAIL pc: got pc=%h addr=%h, want pc=%h", pc_out, imem_addr, m_pc);
      end
      n_cmp++;
      if (if_id_valid !== m_valid || fetch_fault !== m_fault) begin
         n_bad++; $display("FAIL flags: got valid=%b fault=%b, want valid=%b fault=%b",
                           if_id_valid, fetch_fault, m_valid, m_fault);
      end
      if (push) begin
         e = sb.pop_front();
         m_instr = e[63:32];
         n_cmp++;
         if (if_id_instr !== e[63:32] || if_id_pc_plus4 !== e[31:0]) begin
            n_bad++; $display("FAIL fetch: got %h/%h, want %h/%h",
                              if_id_instr, if_id_pc_plus4, e[63:32], e[31:0]);
         end
      end else begin
         n_cmp++;
         if (if_id_instr !== m_instr) begin
            n_bad++; $display("FAIL hold_or_nop: got instr=%h, want %h", if_id_instr, m_instr);
         end
      end
`ifdef IF_PERF_CNT_EN
      n_cmp++;
      if (perf_fetched !== m_fetched || perf_stalls !== m_stalls) begin
         n_bad++; $display("FAIL perf: got %0d/%0d, want %0d/%0d",
                           perf_fetched, perf_stalls, m_fetched, m_stalls);
      end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_reset();
      @(posedge clk); #1;
      n_cmp++;
      if (pc_out !== 32'h0 || if_id_instr !== NOP || if_id_pc_plus4 !== 32'h0 ||
          if_id_valid !== 1'b0 || fetch_fault !== 1'b0) begin
         n_bad++; $display("FAIL reset: pc=%h instr=%h pp4=%h valid=%b fault=%b, want zeros",
                           pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault);
      end
`ifdef IF_PERF_CNT_EN
      n_cmp++;
      if (perf_fetched !== 0 || perf_stalls !== 0) begin
         n_bad++; $display("FAIL reset_perf: got %0d/%0d, want 0/0", perf_fetched, perf_stalls);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      step(0, 0, 0, 0);
      n_cmp++;
      if (if_id_valid !== 1'b0 || pc_out !== 32'h0) begin
         n_bad++; $display("FAIL boot: valid=%b pc=%h, want 0/0", if_id_valid, pc_out);
      end
      step(0, 0, 0, 0);
      n_cmp++;
      if (if_id_instr !== 32'h0022_1820 || if_id_pc_plus4 !== 32'd4) begin
         n_bad++; $display("FAIL first_word: got %h/%h, want 00221820/4", if_id_instr, if_id_pc_plus4);
      end
      step(0, 0, 0, 0);
      n_cmp++;
      if (if_id_instr !== 32'h0125_5022 || if_id_pc_plus4 !== 32'd8) begin
         n_bad++; $display("FAIL second_word: got %h/%h, want 01255022/8", if_id_instr, if_id_pc_plus4);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         n_cmp++;
         if (pc_out !== 32'h8 || if_id_instr !== 32'h0125_5022 || if_id_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold: pc=%h instr=%h valid=%b, want 8/01255022/1",
                              pc_out, if_id_instr, if_id_valid);
         end
      end
      step(0, 0, 0, 0);
   endtask

   task automatic test_redirect();
      step(0, 1, 1, 32'h0000_0013);
      n_cmp++;
      if (pc_out !== 32'h10 || if_id_valid !== 1'b0) begin
         n_bad++; $display("FAIL redirect: pc=%h valid=%b, want 10/0", pc_out, if_id_valid);
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
   endtask

   task automatic test_stall_flush();
      logic [31:0] p;
      p = m_pc;
      step(1, 1, 0, 0);
      n_cmp++;
      if (pc_out !== p || if_id_instr !== NOP || if_id_valid !== 1'b0) begin
         n_bad++; $display("FAIL stall_flush: pc=%h instr=%h valid=%b, want %h/0/0",
                           pc_out, if_id_instr, if_id_valid, p);
      end
      step(0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0)
            step(0, 1, 1, {23'd0, 9'($urandom_range(0, 480))});
         else
            step(1'($urandom_range(0, 9) < 3), 0, 0, 0);
      end
   endtask

   task automatic test_fault();
      step(0, 1, 1, 32'h0000_01F8);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      n_cmp++;
      if (pc_out !== 32'h200 || fetch_fault !== 1'b0) begin
         n_bad++; $display("FAIL pre_fault: pc=%h fault=%b, want 200/0", pc_out, fetch_fault);
      end
      step(0, 0, 0, 0);
      n_cmp++;
      if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || pc_out !== 32'h200) begin
         n_bad++; $display("FAIL fault: fault=%b valid=%b pc=%h, want 1/0/200",
                           fetch_fault, if_id_valid, pc_out);
      end
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 1, 32'h0);
      n_cmp++;
      if (fetch_fault !== 1'b0 || pc_out !== 32'h0) begin
         n_bad++; $display("FAIL fault_exit: fault=%b pc=%h, want 0/0", fetch_fault, pc_out);
      end
      step(0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pc_out !== 32'h0 || if_id_instr !== NOP || if_id_pc_plus4 !== 32'h0 ||
          if_id_valid !== 1'b0 || fetch_fault !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: pc=%h instr=%h pp4=%h valid=%b fault=%b, want zeros",
                           pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_perf();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
      n_cmp++;
      if (perf_fetched !== 32'd5 || perf_stalls !== 32'd2) begin
         n_bad++; $display("FAIL perf_5_2: got %0d/%0d, want 5/2", perf_fetched, perf_stalls);
      end
`endif
      n_cmp++;
      if (pc_out !== 32'd20) begin
         n_bad++; $display("FAIL perf_pc: got %h, want 14", pc_out);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | (i * 32'h0001_0101);
      mem[0] = 32'h0022_1820;
      mem[1] = 32'h0125_5022;
      #1;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_stall_flush();
      test_back_to_back();
      test_fault();
      test_async_reset();
      test_perf();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
